sc_mux_add: RTL and testbench
=============================

SC_MUX_ADD -- requirements
Module: sc_mux_add

Interface
REQ-001 Parameter W, default 2: bit width of each input lane and of the output.
REQ-002 Parameter NCH, default 4: number of input channels; power of two, 2..16.
REQ-003 Parameter LEN, default 256: bitstream length in accepted samples; 2..65535.
REQ-004 Parameter SEED, default 16'hACE1: LFSR reload value; nonzero.
REQ-005 Derived SELW = clog2(NCH); CW = clog2(LEN+1).
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  begin one stream run; sampled only in IDLE.
REQ-009 mode  in  1  select source: 0 = LFSR pseudo-random, 1 = round-robin; sampled with start.
REQ-010 in_data  in  NCH*W  lane k at bits [k*W+W-1 : k*W].
REQ-011 in_valid  in  1  in_data valid this cycle.
REQ-012 in_ready  out  1  block accepts in_data this cycle.
REQ-013 out_data  out  W  registered selected lane.
REQ-014 out_valid  out  1  out_data valid.
REQ-015 out_sel  out  SELW  channel index that produced out_data.
REQ-016 ones_cnt  out  CW  running count of accepted samples whose selected lane bit 0 was 1.
REQ-017 busy  out  1  high in RUN.
REQ-018 done  out  1  one-cycle pulse at end of run.

Function
REQ-019 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-020 IDLE: in_ready=0; start=1 -> RUN next cycle; latch mode; load LFSR=SEED, rr=0, sample count=0, ones_cnt=0.
REQ-021 RUN: in_ready=1; accept = in_valid & in_ready.
REQ-022 On accept: sel = lfsr[SELW-1:0] (mode 0) or rr (mode 1); out_data <= lane sel; out_sel <= sel; out_valid <= 1 (latency 1 cycle).
REQ-023 On accept: ones_cnt += lane sel bit 0; sample count += 1; LFSR steps (mode 0) or rr = (rr+1) mod NCH (mode 1).
REQ-024 LFSR: 16-bit Fibonacci, taps 16,14,13,11; shift left, new bit into bit 0; never advances without accept.
REQ-025 No accept in RUN (in_valid=0): out_valid <= 0; LFSR, rr, counters hold.
REQ-026 Accept of sample LEN (count reaches LEN) -> DONE next cycle; that sample's out_valid still asserts normally.
REQ-027 DONE: in_ready=0, out_valid=0, done=1 for exactly one cycle -> IDLE; ones_cnt holds final value until next start.
REQ-028 start in RUN or DONE is ignored; mode changes outside start are ignored.
REQ-029 ones_cnt never exceeds LEN; no wrap.
REQ-030 busy=1 iff state is RUN.

Reset
REQ-031 rst asserted: immediately state=IDLE, in_ready=0, out_valid=0, out_data=0, out_sel=0, ones_cnt=0, busy=0, done=0, LFSR=SEED, rr=0.
REQ-032 rst mid-RUN aborts the run; no done pulse; next run restarts from SEED.

Verification
REQ-033 mode=1, NCH=4, LEN=8, lanes={0,1,0,1} constant, in_valid=1 -> out_sel 0,1,2,3,0,1,2,3; ones_cnt=4; done 1 cycle after 8th accept.
REQ-034 mode=0, LEN=256, lane0=1, others 0 -> out_sel matches reference LFSR from 16'hACE1; ones_cnt equals count of sel==0.
REQ-035 mode=1, in_valid toggled 1,0,1,0 -> out_valid tracks one cycle later; rr advances only on accepts; total 8 accepts still gives done.
REQ-036 rst pulsed after 3 accepts -> all outputs zero immediately, no done; restart reproduces first-run sequence.
REQ-037 start held high during RUN and DONE -> single run only; done pulses once; second run only after start re-sampled in IDLE.
REQ-038 All lanes=2'b11, LEN=255 -> ones_cnt=255, out_data=2'b11 every valid cycle, no counter overflow.

Source files
------------

// File: rtl/sc_mux_add.sv
// sc_mux_add: stochastic-computing multiplexer adder. Each accepted sample selects one
// input lane (LFSR or round-robin), registers it, and counts selected lanes whose bit 0 is set.
module sc_mux_add #(
    parameter int          W    = 2,
    parameter int          NCH  = 4,
    parameter int          LEN  = 256,
    parameter logic [15:0] SEED = 16'hACE1,
    localparam int         SELW = $clog2(NCH),
    localparam int         CW   = $clog2(LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [NCH*W-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [W-1:0]      out_data,
    output logic              out_valid,
    output logic [SELW-1:0]   out_sel,
    output logic [CW-1:0]     ones_cnt,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state
);

    // Handshake: a sample transfers on any cycle with in_valid && in_ready; in_ready is
    // high exactly while in RUN and never depends on in_valid.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic            mode_q;
    logic [15:0]     lfsr;
    logic [15:0]     lfsr_nxt;
    logic [SELW-1:0] rr;
    logic [SELW-1:0] sel;
    logic [CW-1:0]   cnt;
    logic            accept;
    logic            last;
    logic [W-1:0]    lanes [NCH];

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        assign lanes[k] = in_data[k*W +: W];
    end

    assign accept    = in_valid && (state == S_RUN);
    assign sel       = mode_q ? rr : lfsr[SELW-1:0];
    assign last      = (cnt == CW'(LEN - 1));
    // Fibonacci taps 16,14,13,11 map to bits 15,13,12,10.
    assign lfsr_nxt  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    assign in_ready  = (state == S_RUN);
    assign busy      = (state == S_RUN);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (accept && last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= 1'b0;
            lfsr      <= SEED;
            rr        <= '0;
            cnt       <= '0;
            ones_cnt  <= '0;
            out_data  <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= accept;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q   <= mode;
                        lfsr     <= SEED;
                        rr       <= '0;
                        cnt      <= '0;
                        ones_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        out_data <= lanes[sel];
                        out_sel  <= sel;
                        ones_cnt <= ones_cnt + CW'(lanes[sel][0]);
                        cnt      <= cnt + CW'(1);
                        if (mode_q) begin
                            rr <= rr + SELW'(1);
                        end else begin
                            lfsr <= lfsr_nxt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sc_mux_add.sv
// Directed bench for sc_mux_add: LEN=8 instance for tables and reset/start corners,
// plus LEN=256 (LFSR reference) and LEN=255 (all-ones) instances.
module tb_sc_mux_add;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_a, start_b, start_c;
    logic       mode;
    logic       in_valid;
    logic [7:0] in_data;

    logic       a_in_ready, a_out_valid, a_busy, a_done;
    logic [1:0] a_out_data, a_out_sel, a_dbg;
    logic [3:0] a_ones;
    logic       b_in_ready, b_out_valid, b_busy, b_done;
    logic [1:0] b_out_data, b_out_sel, b_dbg;
    logic [8:0] b_ones;
    logic       c_in_ready, c_out_valid, c_busy, c_done;
    logic [1:0] c_out_data, c_out_sel, c_dbg;
    logic [7:0] c_ones;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [1:0] sel;
        logic [1:0] dat;
        logic [3:0] ones;
    } vec_t;

    vec_t       tbl_rr  [8];
    vec_t       tbl_tog [15];
    logic [1:0] hand    [4];
    logic [1:0] exp_q   [$];

    sc_mux_add #(.W(2), .NCH(4), .LEN(8), .SEED(16'hACE1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .mode(mode), .in_data(in_data),
        .in_valid(in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
        .out_valid(a_out_valid), .out_sel(a_out_sel), .ones_cnt(a_ones),
        .busy(a_busy), .done(a_done), .dbg_state(a_dbg)
    );

    sc_mux_add #(.W(2), .NCH(4), .LEN(256), .SEED(16'hACE1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .mode(mode), .in_data(in_data),
        .in_valid(in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_sel(b_out_sel), .ones_cnt(b_ones),
        .busy(b_busy), .done(b_done), .dbg_state(b_dbg)
    );

    sc_mux_add #(.W(2), .NCH(4), .LEN(255), .SEED(16'hACE1)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .mode(mode), .in_data(in_data),
        .in_valid(in_valid), .in_ready(c_in_ready), .out_data(c_out_data),
        .out_valid(c_out_valid), .out_sel(c_out_sel), .ones_cnt(c_ones),
        .busy(c_busy), .done(c_done), .dbg_state(c_dbg)
    );

    // clock / reset
    initial forever #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard helpers
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // driver tasks
    task automatic apply_vec(input vec_t x, input string tag);
        in_valid = x.v;
        in_data  = x.d;
        tick();
        chk({tag, " out_valid"}, 32'(a_out_valid), 32'(x.v));
        if (x.v) begin
            chk({tag, " out_sel"}, 32'(a_out_sel), 32'(x.sel));
            chk({tag, " out_data"}, 32'(a_out_data), 32'(x.dat));
        end
        chk({tag, " ones_cnt"}, 32'(a_ones), 32'(x.ones));
    endtask

    task automatic start_run_a(input logic m);
        start_a  = 1'b1;
        mode     = m;
        in_valid = 1'b0;
        tick();
        start_a  = 1'b0;
        chk("a start busy", 32'(a_busy), 32'd1);
        chk("a start ones clear", 32'(a_ones), 32'd0);
    endtask

    task automatic chk_a_reset(input string tag);
        chk({tag, " in_ready"}, 32'(a_in_ready), 32'd0);
        chk({tag, " out_valid"}, 32'(a_out_valid), 32'd0);
        chk({tag, " out_data"}, 32'(a_out_data), 32'd0);
        chk({tag, " out_sel"}, 32'(a_out_sel), 32'd0);
        chk({tag, " ones_cnt"}, 32'(a_ones), 32'd0);
        chk({tag, " busy"}, 32'(a_busy), 32'd0);
        chk({tag, " done"}, 32'(a_done), 32'd0);
        chk({tag, " state"}, 32'(a_dbg), 32'd0);
    endtask

    initial begin
        logic [15:0] s;
        logic [1:0]  e;
        int          ones;

        // lanes {3,2,1,0} = {1,0,1,0}: round robin selects 0,1,2,3,...
        for (int i = 0; i < 8; i++) begin
            tbl_rr[i] = '{1'b1, 8'h44, 2'(i % 4), 2'(i % 2), 4'((i + 1) / 2)};
        end
        tbl_tog[0]  = '{1'b1, 8'hE4, 2'd0, 2'd0, 4'd0};
        tbl_tog[1]  = '{1'b0, 8'hFF, 2'd0, 2'd0, 4'd0};
        tbl_tog[2]  = '{1'b1, 8'hE4, 2'd1, 2'd1, 4'd1};
        tbl_tog[3]  = '{1'b0, 8'hFF, 2'd0, 2'd0, 4'd1};
        tbl_tog[4]  = '{1'b1, 8'h1B, 2'd2, 2'd1, 4'd2};
        tbl_tog[5]  = '{1'b0, 8'hFF, 2'd0, 2'd0, 4'd2};
        tbl_tog[6]  = '{1'b1, 8'h1B, 2'd3, 2'd0, 4'd2};
        tbl_tog[7]  = '{1'b0, 8'h00, 2'd0, 2'd0, 4'd2};
        tbl_tog[8]  = '{1'b1, 8'hFF, 2'd0, 2'd3, 4'd3};
        tbl_tog[9]  = '{1'b0, 8'hFF, 2'd0, 2'd0, 4'd3};
        tbl_tog[10] = '{1'b1, 8'h00, 2'd1, 2'd0, 4'd3};
        tbl_tog[11] = '{1'b0, 8'hFF, 2'd0, 2'd0, 4'd3};
        tbl_tog[12] = '{1'b1, 8'h30, 2'd2, 2'd3, 4'd4};
        tbl_tog[13] = '{1'b0, 8'hFF, 2'd0, 2'd0, 4'd4};
        tbl_tog[14] = '{1'b1, 8'h80, 2'd3, 2'd2, 4'd4};
        // first LFSR selections from ACE1, worked by hand: ACE1, 59C3, B387, 670F
        hand = '{2'd1, 2'd3, 2'd3, 2'd3};

        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        mode = 1'b0; in_valid = 1'b0; in_data = 8'h00;

        #2 rst = 1'b1;
        #1 chk_a_reset("reset");
        chk("reset b ones", 32'(b_ones), 32'd0);
        chk("reset c out_valid", 32'(c_out_valid), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // round robin run with start held high and mode wiggled mid-run
        start_a = 1'b1;
        mode    = 1'b1;
        tick();
        chk("rr busy", 32'(a_busy), 32'd1);
        chk("rr in_ready", 32'(a_in_ready), 32'd1);
        mode = 1'b0;
        for (int i = 0; i < 8; i++) apply_vec(tbl_rr[i], $sformatf("rr[%0d]", i));
        chk("rr done", 32'(a_done), 32'd1);
        chk("rr done in_ready", 32'(a_in_ready), 32'd0);
        chk("rr done busy", 32'(a_busy), 32'd0);
        tick();
        chk("rr done pulse end", 32'(a_done), 32'd0);
        chk("rr idle state", 32'(a_dbg), 32'd0);
        chk("rr idle out_valid", 32'(a_out_valid), 32'd0);
        chk("rr ones hold", 32'(a_ones), 32'd4);
        start_a = 1'b0;
        tick();
        chk("rr no restart busy", 32'(a_busy), 32'd0);
        chk("rr no second done", 32'(a_done), 32'd0);
        chk("rr ones hold idle", 32'(a_ones), 32'd4);

        // round robin with in_valid toggling
        start_run_a(1'b1);
        mode = 1'b0;
        for (int i = 0; i < 15; i++) apply_vec(tbl_tog[i], $sformatf("tog[%0d]", i));
        chk("tog done", 32'(a_done), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("tog done end", 32'(a_done), 32'd0);
        chk("tog ones final", 32'(a_ones), 32'd4);

        // LFSR run aborted by reset after three accepts
        start_run_a(1'b0);
        in_data = 8'hE4;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            tick();
            chk($sformatf("abort sel[%0d]", i), 32'(a_out_sel), 32'(hand[i]));
            chk($sformatf("abort data[%0d]", i), 32'(a_out_data), 32'(hand[i]));
            chk($sformatf("abort ones[%0d]", i), 32'(a_ones), 32'(i + 1));
        end
        rst = 1'b1;
        #1 chk_a_reset("mid reset");
        tick();
        chk("mid reset no done", 32'(a_done), 32'd0);
        rst = 1'b0;
        tick();
        chk("after reset no done", 32'(a_done), 32'd0);
        chk("after reset idle", 32'(a_dbg), 32'd0);

        start_run_a(1'b0);
        s = 16'hACE1;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            e = s[1:0];
            s = lfsr_step(s);
            ones += int'(e[0]);
            in_valid = 1'b1;
            tick();
            chk($sformatf("restart sel[%0d]", i), 32'(a_out_sel), 32'(e));
            if (i < 4) chk($sformatf("restart hand[%0d]", i), 32'(a_out_sel), 32'(hand[i]));
            chk($sformatf("restart ones[%0d]", i), 32'(a_ones), 32'(ones));
        end
        chk("restart done", 32'(a_done), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("restart done end", 32'(a_done), 32'd0);

        // LEN=256 LFSR run against the reference sequence
        s = 16'hACE1;
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back(s[1:0]);
            s = lfsr_step(s);
        end
        start_b = 1'b1;
        mode    = 1'b0;
        tick();
        start_b = 1'b0;
        in_data = 8'h01;
        ones    = 0;
        for (int i = 0; i < 256; i++) begin
            e = exp_q.pop_front();
            if (e == 2'd0) ones++;
            in_valid = 1'b1;
            tick();
            chk($sformatf("lfsr256 sel[%0d]", i), 32'(b_out_sel), 32'(e));
            chk($sformatf("lfsr256 data[%0d]", i), 32'(b_out_data), (e == 2'd0) ? 32'd1 : 32'd0);
            chk($sformatf("lfsr256 ones[%0d]", i), 32'(b_ones), 32'(ones));
        end
        chk("lfsr256 done", 32'(b_done), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("lfsr256 done end", 32'(b_done), 32'd0);
        chk("lfsr256 ones final", 32'(b_ones), 32'(ones));

        // LEN=255 all-ones run: count reaches LEN without wrapping
        start_c = 1'b1;
        mode    = 1'b1;
        tick();
        start_c = 1'b0;
        in_data = 8'hFF;
        for (int i = 0; i < 255; i++) begin
            in_valid = 1'b1;
            tick();
            chk($sformatf("ones255 data[%0d]", i), 32'(c_out_data), 32'd3);
            chk($sformatf("ones255 cnt[%0d]", i), 32'(c_ones), 32'(i + 1));
        end
        chk("ones255 done", 32'(c_done), 32'd1);
        tick();
        chk("ones255 final", 32'(c_ones), 32'd255);
        chk("ones255 no accept", 32'(c_out_valid), 32'd0);
        in_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
